// File: rtl/ic_trace_fifo.sv
// Trace-capture FIFO: timestamps probe events and buffers (ts, tag, value, drop) records
// in a first-word-fall-through queue drained over a valid/ready port.
module ic_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     probe_valid,
  input  logic [TAG_W-1:0]         probe_tag,
  input  logic [DATA_W-1:0]        probe_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [TAG_W-1:0]         out_tag,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_drop,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              pending_q, pending_d;

  logic [TS_W-1:0]   ts_mem   [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              drop_mem [DEPTH];

  logic capture, full, pop, write, drop;

  // DEPTH is a power of two, so the MSB of the level alone marks a full FIFO.
  assign full    = level_q[AW];
  assign capture = probe_valid & enable & ~clear;
  assign pop     = out_valid & out_ready & ~clear;
  assign write   = capture & (~full | pop);
  assign drop    = capture & ~write;

  always_comb begin
    ts_d       = ts_q + 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    pending_d  = pending_q;

    if (clear) begin
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drop_cnt_d = '0;
      pending_d  = 1'b0;
    end else begin
      if (write) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        pending_d = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (write && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !write) begin
        level_d = level_q - 1'b1;
      end
      if (drop) begin
        pending_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      pending_q  <= pending_d;
    end
  end

  // Storage needs no reset: every read of it is gated by out_valid.
  always_ff @(posedge clk) begin
    if (write) begin
      ts_mem[wr_ptr_q]   <= ts_q;
      tag_mem[wr_ptr_q]  <= probe_tag;
      data_mem[wr_ptr_q] <= probe_data;
      drop_mem[wr_ptr_q] <= pending_q;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_ts    = out_valid ? ts_mem[rd_ptr_q]   : '0;
  assign out_tag   = out_valid ? tag_mem[rd_ptr_q]  : '0;
  assign out_data  = out_valid ? data_mem[rd_ptr_q] : '0;
  assign out_drop  = out_valid ? drop_mem[rd_ptr_q] : 1'b0;
  assign level     = level_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
